// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational ALU port: accepts commands over valid/ready,
// issues registered operands, captures the result and returns it over valid/ready.
module alu_cmd_sequencer #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [W-1:0]     cmd_a,
   input  logic [W-1:0]     cmd_b,
   input  logic             cmd_chain,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic [3:0]       alu_op,
   input  logic [W-1:0]     alu_out,
   input  logic [3:0]       alu_flag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res_data,
   output logic [3:0]       res_flag,
   output logic             res_err,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t       state, state_nxt;
   logic         accept;
   logic         bad_cmd;
   logic [W-1:0] last_res;

   assign accept  = cmd_valid && (state == IDLE);
   assign bad_cmd = (cmd_op > 4'hB) || ((cmd_op == 4'h3) && (cmd_b == '0));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bad_cmd ? DONE : EXEC;
         EXEC:    state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      res_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= 4'hF;
         res_data  <= '0;
         res_flag  <= '0;
         res_err   <= 1'b0;
         last_res  <= '0;
         op_count  <= '0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Rejected commands leave the ALU operands untouched.
               if (accept) begin
                  if (bad_cmd) begin
                     res_err  <= 1'b1;
                     res_data <= '0;
                     res_flag <= '0;
                  end else begin
                     alu_op <= cmd_op;
                     alu_b  <= cmd_b;
                     alu_a  <= cmd_chain ? last_res : cmd_a;
                  end
               end
            end
            EXEC: begin
               res_data <= alu_out;
               res_flag <= alu_flag;
               res_err  <= 1'b0;
               last_res <= alu_out;
            end
            DONE: begin
               if (res_ready) begin
                  if (op_count != '1) op_count <= op_count + CNT_W'(1);
                  if (res_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a reference ALU drives alu_out/alu_flag, a queue
// model predicts every result and handshake, and directed literals pin the model.
module tb_alu_cmd_sequencer;

   localparam int W     = 8;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid, cmd_ready, cmd_chain;
   logic [3:0]       cmd_op;
   logic [W-1:0]     cmd_a, cmd_b;
   logic [W-1:0]     alu_a, alu_b, alu_out;
   logic [3:0]       alu_op, alu_flag;
   logic             res_valid, res_ready, res_err, busy;
   logic [W-1:0]     res_data;
   logic [3:0]       res_flag;
   logic [CNT_W-1:0] op_count, err_count;

   int checks = 0;
   int errors = 0;

   alu_cmd_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_flag(alu_flag),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_flag(res_flag), .res_err(res_err),
      .busy(busy), .op_count(op_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Reference ALU: {flag[3:0], out[7:0]}
   function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
      logic [8:0]  s;
      logic [15:0] p;
      logic [7:0]  o;
      logic [3:0]  f;
      s = '0; p = '0; o = '0; f = '0;
      case (op)
         4'h0: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; f[1] = s[8]; end
         4'h1: begin o = a - b; f[3] = (a < b); end
         4'h2: begin p = 16'(a) * 16'(b); o = p[7:0]; f[2] = |p[15:8]; end
         4'h3: o = (b == 8'h00) ? 8'hFF : a / b;
         4'h4: o = a & b;
         4'h5: o = a | b;
         4'h6: o = a ^ b;
         4'h7: o = a << b[2:0];
         4'h8: o = a >> b[2:0];
         4'h9: o = ~a;
         4'hA: begin s = {1'b0, a} + 9'd1; o = s[7:0]; f[1] = s[8]; end
         4'hB: begin o = a - 8'd1; f[3] = (a == 8'h00); end
         default: o = '0;
      endcase
      if (op <= 4'hB) f[0] = (o == 8'h00);
      return {f, o};
   endfunction

   always_comb {alu_flag, alu_out} = alu_f(alu_a, alu_b, alu_op);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding command, result known at accept.
   typedef struct {logic [7:0] d; logic [3:0] f; logic e;} res_t;
   res_t       exp_q[$];
   bit         m_on = 1'b0;
   bit         pending;
   int         wait_c;
   logic [7:0] m_last;
   int         m_ops, m_errs;

   always @(posedge clk) begin
      res_t       r;
      logic [11:0] y;
      if (rst) begin
         exp_q.delete();
         pending = 1'b0; wait_c = 0; m_last = '0; m_ops = 0; m_errs = 0; m_on = 1'b1;
      end else if (m_on) begin
         if (pending) begin
            if (wait_c > 0) wait_c--;
            else if (res_ready) begin
               r = exp_q.pop_front();
               if (m_ops < CMAX) m_ops++;
               if (r.e && m_errs < CMAX) m_errs++;
               pending = 1'b0;
            end
         end else if (cmd_valid) begin
            if (cmd_op > 4'hB || (cmd_op == 4'h3 && cmd_b == 8'h00)) begin
               r.d = '0; r.f = '0; r.e = 1'b1; wait_c = 0;
            end else begin
               y = alu_f(cmd_chain ? m_last : cmd_a, cmd_b, cmd_op);
               r.d = y[7:0]; r.f = y[11:8]; r.e = 1'b0; wait_c = 1;
               m_last = y[7:0];
            end
            exp_q.push_back(r);
            pending = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_on && !rst) begin
         chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !pending});
         chk("busy", {31'b0, busy}, {31'b0, pending});
         chk("res_valid", {31'b0, res_valid}, {31'b0, pending && wait_c == 0});
         if (pending && wait_c == 0 && exp_q.size() > 0) begin
            chk("res_data", {24'b0, res_data}, {24'b0, exp_q[0].d});
            chk("res_flag", {28'b0, res_flag}, {28'b0, exp_q[0].f});
            chk("res_err", {31'b0, res_err}, {31'b0, exp_q[0].e});
         end
         chk("op_count", {28'b0, op_count}, m_ops);
         chk("err_count", {28'b0, err_count}, m_errs);
      end
   end

   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ch);
      int n = 0;
      @(negedge clk);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get(output logic [7:0] d, output logic [3:0] f, output logic e,
                      output int lat);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!res_valid && lat < 20);
      if (!res_valid) chk("result_timeout", 32'd0, 32'd1);
      d = res_data; f = res_flag; e = res_err;
   endtask

   logic [7:0] d;
   logic [3:0] f;
   logic       e;
   int         lat;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      cmd_chain = 1'b0; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_alu_op", {28'b0, alu_op}, 32'hF);
      chk("rst_alu_a", {24'b0, alu_a}, 32'h0);
      chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;

      send(4'h0, 8'h05, 8'h03, 1'b0); get(d, f, e, lat);
      chk("add_data", {24'b0, d}, 32'h08); chk("add_flag", {28'b0, f}, 32'h0);
      chk("add_err", {31'b0, e}, 32'h0);   chk("add_lat", lat, 2);

      send(4'h1, 8'h03, 8'h05, 1'b0); get(d, f, e, lat);
      chk("sub_data", {24'b0, d}, 32'hFE); chk("sub_flag", {28'b0, f}, 32'h8);
      send(4'h0, 8'hAA, 8'h02, 1'b1); get(d, f, e, lat);
      chk("chain_data", {24'b0, d}, 32'h00); chk("chain_flag", {28'b0, f}, 32'h3);

      send(4'h3, 8'h10, 8'h00, 1'b0); get(d, f, e, lat);
      chk("div0_err", {31'b0, e}, 32'h1); chk("div0_data", {24'b0, d}, 32'h0);
      chk("div0_lat", lat, 1);
      @(negedge clk);
      chk("div0_errcnt", {28'b0, err_count}, 32'd1);
      chk("div0_opcnt", {28'b0, op_count}, 32'd4);

      send(4'h0, 8'h40, 8'h02, 1'b0); get(d, f, e, lat);
      send(4'hC, 8'h11, 8'h22, 1'b0); get(d, f, e, lat);
      chk("illegal_err", {31'b0, e}, 32'h1);
      send(4'h7, 8'h00, 8'h01, 1'b1); get(d, f, e, lat);
      chk("chain_after_err", {24'b0, d}, 32'h84);

      @(negedge clk); res_ready = 1'b0;
      send(4'h2, 8'h20, 8'h10, 1'b0); get(d, f, e, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_data", {24'b0, res_data}, 32'h00);
         chk("stall_flag", {28'b0, res_flag}, 32'h5);
         chk("stall_ready", {31'b0, cmd_ready}, 32'h0);
         chk("stall_opcnt", {28'b0, op_count}, 32'd7);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("stall_release", {28'b0, op_count}, 32'd8);

      send(4'h0, 8'h01, 8'h01, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'b0, res_valid}, 32'h0);
      chk("mid_rst_op", {28'b0, alu_op}, 32'hF);
      chk("mid_rst_b", {24'b0, alu_b}, 32'h0);
      chk("mid_rst_cnt", {28'b0, op_count}, 32'h0);
      chk("mid_rst_ready", {31'b0, cmd_ready}, 32'h1);
      send(4'h0, 8'h77, 8'h01, 1'b1); get(d, f, e, lat);
      chk("rst_last_res", {24'b0, d}, 32'h01);

      for (int i = 0; i < 16; i++)
         send(4'(i), 8'($urandom_range(0, 255)), 8'(i * 37 + 3), i[0]);
      for (int i = 0; i < 17; i++) send(4'hF, 8'h00, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      chk("op_sat", {28'b0, op_count}, CMAX);
      chk("err_sat", {28'b0, err_count}, CMAX);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
